// File: rtl/briscv_loader_pkg.sv
// Shared types and constants for the briscv program loader.
package briscv_loader_pkg;

  localparam int unsigned LOADER_BYTES_PER_WORD = 4;
  localparam int unsigned LOADER_COUNT_BITS     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StCsum,
    StStart,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/briscv_program_loader_if.sv
// Byte-stream input and word write port of the program loader.
interface briscv_program_loader_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 10
);
  logic [7:0]                  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        mem_we;
  logic [MEM_ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/briscv_word_packer.sv
// Collects accepted stream bytes into little-endian words; word_valid marks the final byte.
module briscv_word_packer
  import briscv_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);
  localparam int unsigned LaneBits = $clog2(LOADER_BYTES_PER_WORD);

  logic [LaneBits-1:0]   lane_q;
  logic [DATA_WIDTH-9:0] shift_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clear) begin
      lane_q  <= '0;
    end else if (byte_valid) begin
      // Newest byte enters at the top so the first byte ends up least significant.
      shift_q <= {byte_data, shift_q[DATA_WIDTH-9:8]};
      lane_q  <= lane_q + LaneBits'(1);
    end
  end

  assign word_valid = byte_valid && (lane_q == LaneBits'(LOADER_BYTES_PER_WORD - 1));
  assign word       = {byte_data, shift_q};

endmodule

// File: rtl/briscv_program_loader.sv
// Framed byte-stream program loader: writes image words, verifies checksum, releases the core.
module briscv_program_loader
  import briscv_loader_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH       = 32,
  parameter int unsigned             ADDRESS_BITS     = 32,
  parameter int unsigned             MEM_ADDRESS_BITS = 10,
  parameter logic [ADDRESS_BITS-1:0] START_ADDRESS    = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  briscv_program_loader_if.slave  bus,
  output logic                    core_hold,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] program_address,
  output logic                    done,
  output logic                    error
);
  localparam int unsigned MaxWords = 2 ** MEM_ADDRESS_BITS;

  loader_state_e               state_q;
  logic                        in_ready_q, mem_we_q, core_hold_q, start_q, done_q, error_q;
  logic [MEM_ADDRESS_BITS-1:0] mem_addr_q, next_addr_q;
  logic [DATA_WIDTH-1:0]       mem_wdata_q;
  logic [7:0]                  hdr_lo_q, sum_q;
  logic                        hdr_seen_q;
  logic [LOADER_COUNT_BITS-1:0] remaining_q;

  logic                         accept, data_accept, load_ok, word_valid;
  logic [DATA_WIDTH-1:0]        word;
  logic [LOADER_COUNT_BITS-1:0] count;

  assign accept      = bus.in_valid & in_ready_q;
  assign data_accept = accept && (state_q == StData);
  assign load_ok     = load && (state_q inside {StIdle, StDone, StError});
  assign count       = {bus.in_data, hdr_lo_q};

  briscv_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (load_ok),
    .byte_valid(data_accept),
    .byte_data (bus.in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      next_addr_q <= '0;
      hdr_lo_q    <= '0;
      hdr_seen_q  <= 1'b0;
      sum_q       <= '0;
      remaining_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      start_q  <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (load) begin
            state_q     <= StHdr;
            in_ready_q  <= 1'b1;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            sum_q       <= '0;
            hdr_seen_q  <= 1'b0;
            next_addr_q <= '0;
          end
        end
        StHdr: begin
          if (accept) begin
            if (!hdr_seen_q) begin
              hdr_lo_q   <= bus.in_data;
              hdr_seen_q <= 1'b1;
            end else if (count == '0 || 32'(count) > MaxWords) begin
              state_q    <= StError;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q     <= StData;
              remaining_q <= count;
            end
          end
        end
        StData: begin
          if (accept) sum_q <= sum_q + bus.in_data;
          if (word_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= next_addr_q;
            mem_wdata_q <= word;
            // Wraps to 0 after a full-size image; that is the expected end state.
            next_addr_q <= next_addr_q + MEM_ADDRESS_BITS'(1);
            remaining_q <= remaining_q - LOADER_COUNT_BITS'(1);
            if (remaining_q == LOADER_COUNT_BITS'(1)) state_q <= StCsum;
          end
        end
        StCsum: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == sum_q) begin
              state_q     <= StStart;
              start_q     <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
        StStart: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign core_hold        = core_hold_q;
  assign start            = start_q;
  assign done             = done_q;
  assign error            = error_q;
  assign program_address  = START_ADDRESS;

endmodule

// File: tb/tb_briscv_program_loader.sv
// Randomized self-checking bench for briscv_program_loader against a frame-level reference model.
module tb_briscv_program_loader;

  logic        clock;
  logic        reset;
  logic        load;
  logic        core_hold;
  logic        start;
  logic [31:0] program_address;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_words[$];

  briscv_program_loader_if #(.DATA_WIDTH(32), .MEM_ADDRESS_BITS(10)) bus ();

  briscv_program_loader #(
    .DATA_WIDTH      (32),
    .ADDRESS_BITS    (32),
    .MEM_ADDRESS_BITS(10),
    .START_ADDRESS   (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load           (load),
    .bus            (bus),
    .core_hold      (core_hold),
    .start          (start),
    .program_address(program_address),
    .done           (done),
    .error          (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (bus.mem_we) begin
        got_addr.push_back(bus.mem_addr);
        got_data.push_back(bus.mem_wdata);
      end
      if (start) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    bit acc = 1'b0;
    int waited = 0;
    if (throttle) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clock); #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!acc && waited < 200) begin
      acc = bus.in_ready;
      @(posedge clock); #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 1);
  endtask

  task automatic make_frame(input int n, input bit zero_data, input bit corrupt,
                            output logic [7:0] fr[$]);
    logic [7:0] s = 8'h00;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = zero_data ? 8'h00 : 8'($urandom);
      fr.push_back(b);
      s = s + b;
    end
    fr.push_back(corrupt ? s + 8'h01 : s);
  endtask

  // Frames passed here hold only the bytes the loader is expected to consume.
  task automatic run_frame(input string name, input logic [7:0] fr[$], input bit throttle,
                           input bit poke_load);
    int         n;
    int         mism;
    bit         hdr_bad;
    bit         exp_ok;
    logic [7:0] sum;
    int         b;

    n = int'(fr[0]) + 256 * int'(fr[1]);
    hdr_bad = (n == 0) || (n > 1024);
    exp_words.delete();
    sum = 8'h00;
    if (!hdr_bad) begin
      for (int i = 0; i < n; i++) begin
        b = 2 + 4 * i;
        exp_words.push_back({fr[b+3], fr[b+2], fr[b+1], fr[b]});
        sum = sum + fr[b] + fr[b+1] + fr[b+2] + fr[b+3];
      end
    end
    exp_ok = !hdr_bad && (fr[2 + 4 * n] == sum);

    got_addr.delete();
    got_data.delete();
    start_cnt = 0;

    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    check({name, ":hold_after_load"}, 32'(core_hold), 1);
    check({name, ":ready_after_load"}, 32'(bus.in_ready), 1);
    check({name, ":done_cleared"}, 32'(done), 0);
    check({name, ":error_cleared"}, 32'(error), 0);

    foreach (fr[i]) begin
      if (poke_load && i == 5) load = 1'b1;
      send_byte(fr[i], throttle);
      load = 1'b0;
    end

    if (exp_ok) begin
      check({name, ":start_pulse"}, 32'(start), 1);
      check({name, ":hold_low_at_start"}, 32'(core_hold), 0);
      check({name, ":program_address"}, program_address, 32'h0);
      @(posedge clock); #1;
      check({name, ":done_after_start"}, 32'(done), 1);
      check({name, ":start_one_cycle"}, 32'(start), 0);
    end else begin
      check({name, ":error_timing"}, 32'(error), 1);
      check({name, ":ready_drop"}, 32'(bus.in_ready), 0);
    end

    repeat (3) @(posedge clock);
    #1;
    check({name, ":done_final"}, 32'(done), 32'(exp_ok));
    check({name, ":error_final"}, 32'(error), 32'(!exp_ok));
    check({name, ":hold_final"}, 32'(core_hold), 32'(!exp_ok));
    check({name, ":start_count"}, start_cnt, 32'(exp_ok));
    check({name, ":write_count"}, got_data.size(), exp_words.size());
    mism = 0;
    foreach (exp_words[i]) begin
      if (i >= got_data.size()) mism++;
      else if (got_addr[i] !== 10'(i) || got_data[i] !== exp_words[i]) mism++;
    end
    check({name, ":write_mismatches"}, mism, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fr[$];
    logic [31:0] first_data[$];

    reset        = 1'b0;
    load         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("reset:in_ready", 32'(bus.in_ready), 0);
    check("reset:mem_we", 32'(bus.mem_we), 0);
    check("reset:mem_addr", 32'(bus.mem_addr), 0);
    check("reset:mem_wdata", bus.mem_wdata, 0);
    check("reset:core_hold", 32'(core_hold), 0);
    check("reset:start", 32'(start), 0);
    check("reset:done", 32'(done), 0);
    check("reset:error", 32'(error), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    run_frame("nominal", fr, 1'b0, 1'b0);
    fr[10] = 8'hB7;
    run_frame("bad_csum", fr, 1'b0, 1'b0);

    fr = '{8'h00, 8'h00};
    run_frame("zero_len", fr, 1'b0, 1'b0);
    fr = '{8'h01, 8'h04};
    run_frame("oversize", fr, 1'b0, 1'b0);

    make_frame(1024, 1'b1, 1'b0, fr);
    run_frame("max_size", fr, 1'b0, 1'b0);
    check("max_size:last_addr", 32'(got_addr[got_addr.size() - 1]), 1023);

    make_frame(3, 1'b0, 1'b0, fr);
    run_frame("n3_plain", fr, 1'b0, 1'b0);
    first_data = got_data;
    run_frame("n3_throttled", fr, 1'b1, 1'b0);
    check("throttle_same_writes", 32'(first_data == got_data), 1);

    for (int k = 0; k < 6; k++) begin
      make_frame($urandom_range(1, 8), 1'b0, $urandom_range(0, 3) == 0, fr);
      run_frame($sformatf("rand%0d", k), fr, k[0], k == 2);
    end

    // Reset two bytes into word 1 of an N=2 frame.
    make_frame(2, 1'b0, 1'b0, fr);
    got_data.delete();
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(fr[i], 1'b0);
    reset = 1'b0;
    #1;
    check("midreset:in_ready", 32'(bus.in_ready), 0);
    check("midreset:mem_we", 32'(bus.mem_we), 0);
    check("midreset:mem_addr", 32'(bus.mem_addr), 0);
    check("midreset:mem_wdata", bus.mem_wdata, 0);
    check("midreset:core_hold", 32'(core_hold), 0);
    check("midreset:start", 32'(start), 0);
    check("midreset:done", 32'(done), 0);
    check("midreset:error", 32'(error), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("midreset:writes_before", got_data.size(), 1);
    run_frame("after_reset", fr, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
